// File: rtl/bus_arbiter.sv
//==============================================================================
// Module   : bus_arbiter
// Summary  : Round-robin shared-bus arbiter with a registered one-hot grant and
//            a mandatory one-cycle zero-grant gap between owners.
//            Optional watchdog enabled by macro BUS_ARBITER_WATCHDOG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   systemClock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] requestBus,
    output logic [NUM_MASTERS-1:0] busGrant,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   busErrorIn,
    output logic [2:0]             grantIndex,
    output logic                   busIdle,
    output logic                   timeoutError
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [2:0]             r_index;
    logic [2:0]             r_pointer;
    logic [2:0]             w_winner;
    logic [2:0]             w_hi;
    logic [2:0]             w_lo;
    logic                   w_hi_found;
    logic                   w_lo_found;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic                   w_owner_req;
    logic                   w_timeout;

    // Bus errors never affect arbitration; the owner must still end or drop.
    logic [16:0] w_unused_bits;
    assign w_unused_bits = {busErrorIn, 16'(TIMEOUT_CYCLES)};

    // Round-robin: lowest requester at/above the pointer, else lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = 3'd0;
        w_lo       = 3'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (requestBus[i]) begin
                if (!w_hi_found && (i >= int'(r_pointer))) begin
                    w_hi_found = 1'b1;
                    w_hi       = 3'(i);
                end
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo       = 3'(i);
                end
            end
        end
        w_winner = w_hi_found ? w_hi : w_lo;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_onehot[i] = (3'(i) == w_winner);
        end
    end

    // The grant register is one-hot on the owner, so this is the owner's request.
    assign w_owner_req = |(requestBus & r_grant);

`ifdef BUS_ARBITER_WATCHDOG_EN
    logic [15:0] r_wd_cnt;
    logic        r_timeout;

    assign w_timeout = ((r_state == ST_GRANTED) || (r_state == ST_ACTIVE)) &&
                       (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            r_wd_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_state_next != r_state) begin
                r_wd_cnt <= 16'd0;
            end else if ((r_state == ST_GRANTED) || (r_state == ST_ACTIVE)) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
        end
    end

    assign timeoutError = r_timeout;
`else
    assign w_timeout    = 1'b0;
    assign timeoutError = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|requestBus) w_state_next = ST_GRANTED;
            end
            ST_GRANTED: begin
                // Begin wins over a same-cycle end; a dropped request wins over begin.
                if (w_timeout || !w_owner_req) w_state_next = ST_RELEASE;
                else if (beginTransactionIn)   w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_timeout || !w_owner_req || endTransactionIn) w_state_next = ST_RELEASE;
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            r_grant   <= '0;
            r_index   <= 3'd0;
            r_pointer <= 3'd0;
        end else if ((r_state == ST_IDLE) && (w_state_next == ST_GRANTED)) begin
            r_grant <= w_onehot;
            r_index <= w_winner;
        end else if ((r_state != ST_RELEASE) && (w_state_next == ST_RELEASE)) begin
            r_grant   <= '0;
            r_pointer <= (r_index == 3'(NUM_MASTERS - 1)) ? 3'd0 : r_index + 3'd1;
        end
    end

    assign busGrant   = r_grant;
    assign grantIndex = r_index;
    assign busIdle    = (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
//==============================================================================
// Module   : tb_bus_arbiter
// Summary  : Directed and random stimulus for bus_arbiter against a
//            behavioural ownership model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] requestBus = '0;
    logic [N-1:0] busGrant;
    logic         beginTransactionIn = 1'b0;
    logic         endTransactionIn = 1'b0;
    logic         busErrorIn = 1'b0;
    logic [2:0]   grantIndex;
    logic         busIdle;
    logic         timeoutError;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, whether their transaction started,
    // whether we are in the mandatory gap, and the round-robin start point.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_started;
    bit m_gap;
    bit m_pulse;
    bit wd_en;

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .systemClock        (clk),
        .reset              (rst_n),
        .requestBus         (requestBus),
        .busGrant           (busGrant),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .busErrorIn         (busErrorIn),
        .grantIndex         (grantIndex),
        .busIdle            (busIdle),
        .timeoutError       (timeoutError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_started = 0;
        m_gap     = 0;
        m_pulse   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic b, input logic e);
        bit to;
        bit drop;
        int c;
        m_pulse = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_owner < 0) begin
            if (rq != '0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (rq[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_started = 0;
                m_held    = 0;
            end
        end else begin
            to   = wd_en && (m_held + 1 >= TO);
            drop = !rq[m_owner];
            if (to || drop || (m_started && e)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
                m_pulse = to;
            end else if (!m_started && b) begin
                m_started = 1;
                m_held    = 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("grant", 32'(busGrant), eg);
        if (m_owner >= 0) chk("index", 32'(grantIndex), 32'(m_owner));
        chk("idle", 32'(busIdle), 32'((m_owner < 0) && !m_gap));
        chk("timeout", 32'(timeoutError), 32'(m_pulse));
        chk("onehot", 32'($onehot0(busGrant)), 32'd1);
    endtask

    // Inputs change just after a falling edge and are stable across the rising edge.
    task automatic step(input logic [N-1:0] rq, input logic b, input logic e, input logic er);
        requestBus         = rq;
        beginTransactionIn = b;
        endTransactionIn   = e;
        busErrorIn         = er;
        @(posedge clk);
        model_step(rq, b, e);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] rq;
`ifdef BUS_ARBITER_WATCHDOG_EN
        wd_en = 1;
`else
        wd_en = 0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(busGrant), 32'd0);
        chk("rst_index", 32'(grantIndex), 32'd0);
        chk("rst_idle", 32'(busIdle), 32'd1);
        chk("rst_timeout", 32'(timeoutError), 32'd0);
        rst_n = 1'b1;

        // Contention: full request held, each owner runs begin/end.
        for (int t = 0; t < 5; t++) begin
            step(4'b1111, 0, 0, 0);
            chk("rr_order", 32'(grantIndex), 32'(exp_order[t]));
            step(4'b1111, 1, 0, 0);
            step(4'b1111, 0, 1, 0);
            chk("rr_gap", 32'(busGrant), 32'd0);
            step(4'b1111, 0, 0, 0);
        end

        // Early drop by master 2 moves the pointer to 3.
        step(4'b0100, 0, 0, 0);
        chk("drop_grant", 32'(busGrant), 32'h4);
        step(4'b0000, 0, 0, 0);
        chk("drop_release", 32'(busGrant), 32'd0);
        step(4'b0000, 0, 0, 0);
        step(4'b1101, 0, 0, 0);
        chk("drop_ptr", 32'(grantIndex), 32'd3);

        // Bus error during ACTIVE does not release the grant.
        step(4'b1000, 1, 0, 0);
        repeat (3) step(4'b1000, 0, 0, 1);
        chk("err_hold", 32'(busGrant), 32'h8);
        step(4'b1000, 0, 1, 0);
        chk("err_release", 32'(busGrant), 32'd0);
        step(4'b0000, 0, 0, 0);

        // Single master, begin+end same cycle while granted, then regrant.
        step(4'b0001, 0, 0, 0);
        chk("single_grant", 32'(busGrant), 32'h1);
        step(4'b0001, 1, 1, 0);
        repeat (3) step(4'b0001, 0, 0, 0);
        step(4'b0001, 0, 1, 0);
        step(4'b0001, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        chk("single_regrant", 32'(busGrant), 32'h1);
        step(4'b0000, 0, 0, 0);
        step(4'b0000, 0, 0, 0);

        // Master 1 granted with no begin: watchdog release or indefinite hold.
        repeat (110) step(4'b0010, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        step(4'b0000, 0, 0, 0);

        // Random traffic.
        rq = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(7, 0) == 0) rq[m] = ~rq[m];
            end
            step(rq, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0));
        end

        // Asynchronous reset between clock edges during ACTIVE.
        step(4'b0000, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        step(4'b0100, 0, 0, 0);
        step(4'b0100, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(busGrant), 32'd0);
        chk("arst_idle", 32'(busIdle), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 0, 0, 0);
        chk("arst_regrant", 32'(grantIndex), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
